// File: rtl/inst_cache_if.sv
// Bundle between the instruction cache, the fetch unit and the memory
// controller's instruction port. The cache is the slave side.
interface inst_cache_if;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        hit_flag;
  logic [31:0] hit_inst;
  logic        inst_IF_req;
  logic [31:0] inst_IF_addr;
  logic        inst_IF_flag;
  logic [31:0] inst_IF;

  modport slave (
    input  fetch_req, fetch_pc, inst_IF_flag, inst_IF,
    output hit_flag, hit_inst, inst_IF_req, inst_IF_addr
  );

  modport master (
    output fetch_req, fetch_pc, inst_IF_flag, inst_IF,
    input  hit_flag, hit_inst, inst_IF_req, inst_IF_addr
  );
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped, one-word-per-line instruction cache. Hits answer in one
// cycle; misses issue a held word fetch and bypass the returned word to fetch.
module inst_cache #(
  parameter int IDX_W = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       jump_wrong,
  inst_cache_if.slave bus
);
  localparam int LINES = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, MISS} state_t;

  state_t            state, state_nx;
  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [31:0]       data_mem [LINES];

  logic [IDX_W-1:0]  idx, miss_idx, miss_idx_nx;
  logic [TAG_W-1:0]  tag, miss_tag, miss_tag_nx;
  logic              hit_q, hit_nx, req_q, req_nx;
  logic [31:0]       inst_q, inst_nx, addr_q, addr_nx;
  logic              lookup, line_hit, fill;
  logic              unused_pc;

  assign idx       = bus.fetch_pc[IDX_W+1:2];
  assign tag       = bus.fetch_pc[31:IDX_W+2];
  assign unused_pc = ^bus.fetch_pc[1:0];

  // A raised hit_flag means the current request was just served; skip it.
  assign lookup   = (state == IDLE) && bus.fetch_req && !hit_q;
  assign line_hit = valid[idx] && (tag_mem[idx] == tag);
  // Fills land even under rdy low or a flush: the word is correct for its address.
  assign fill     = (state == MISS) && bus.inst_IF_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hit_q    <= 1'b0;
      inst_q   <= '0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      miss_idx <= '0;
      miss_tag <= '0;
      valid    <= '0;
    end else begin
      state    <= state_nx;
      hit_q    <= hit_nx;
      inst_q   <= inst_nx;
      req_q    <= req_nx;
      addr_q   <= addr_nx;
      miss_idx <= miss_idx_nx;
      miss_tag <= miss_tag_nx;
      if (fill) valid[miss_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[miss_idx]  <= miss_tag;
      data_mem[miss_idx] <= bus.inst_IF;
    end
  end

  always_comb begin
    state_nx = state;
    if (rdy) begin
      if (jump_wrong) begin
        state_nx = IDLE;
      end else begin
        case (state)
          IDLE: if (lookup && !line_hit) state_nx = MISS;
          MISS: if (bus.inst_IF_flag)    state_nx = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    hit_nx      = 1'b0;
    inst_nx     = inst_q;
    req_nx      = req_q;
    addr_nx     = addr_q;
    miss_idx_nx = miss_idx;
    miss_tag_nx = miss_tag;
    if (rdy) begin
      if (jump_wrong) begin
        req_nx = 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (lookup) begin
              if (line_hit) begin
                hit_nx  = 1'b1;
                inst_nx = data_mem[idx];
              end else begin
                req_nx      = 1'b1;
                addr_nx     = {bus.fetch_pc[31:2], 2'b00};
                miss_idx_nx = idx;
                miss_tag_nx = tag;
              end
            end
          end
          MISS: begin
            if (bus.inst_IF_flag) begin
              hit_nx  = 1'b1;
              inst_nx = bus.inst_IF;
              req_nx  = 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign bus.hit_flag     = hit_q;
  assign bus.hit_inst     = inst_q;
  assign bus.inst_IF_req  = req_q;
  assign bus.inst_IF_addr = addr_q;
endmodule

// File: tb/tb_inst_cache.sv
// Directed plus randomized bench for inst_cache: the bench plays fetch unit and
// memory controller and tracks cache contents with a simple line table.
module tb_inst_cache;
  logic clk = 1'b0;
  logic rst, rdy, jump_wrong;
  int   checks = 0;
  int   errors = 0;

  // Reference line table: index = word address mod 64, tag = pc / 256.
  bit          mv [64];
  logic [31:0] mt [64];
  logic [31:0] md [64];

  inst_cache_if bus ();

  inst_cache #(.IDX_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .jump_wrong (jump_wrong),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  function automatic int unsigned line_of(input logic [31:0] pc);
    return (pc >> 2) % 64;
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return mv[line_of(pc)] && (mt[line_of(pc)] == (pc >> 8));
  endfunction

  task automatic model_fill(input logic [31:0] pc, input logic [31:0] word);
    mv[line_of(pc)] = 1'b1;
    mt[line_of(pc)] = pc >> 8;
    md[line_of(pc)] = word;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) mv[i] = 1'b0;
  endtask

  // Full request: hit or miss decided by the model; the controller answers a
  // miss after a random delay with 'word'. fetch_req is held one cycle past
  // hit_flag to confirm the request is not served twice.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] word);
    bit hit;
    hit           = model_hit(pc);
    bus.fetch_req = 1'b1;
    bus.fetch_pc  = pc;
    tick();
    if (hit) begin
      check("hit_flag", {31'b0, bus.hit_flag}, 32'd1);
      check("hit_inst", bus.hit_inst, md[line_of(pc)]);
      check("hit_noreq", {31'b0, bus.inst_IF_req}, 32'd0);
    end else begin
      check("miss_req", {31'b0, bus.inst_IF_req}, 32'd1);
      check("miss_addr", bus.inst_IF_addr, pc & 32'hFFFF_FFFC);
      check("miss_nohit", {31'b0, bus.hit_flag}, 32'd0);
      repeat ($urandom_range(3, 6)) begin
        tick();
        check("miss_hold_req", {31'b0, bus.inst_IF_req}, 32'd1);
        check("miss_hold_addr", bus.inst_IF_addr, pc & 32'hFFFF_FFFC);
      end
      bus.inst_IF_flag = 1'b1;
      bus.inst_IF      = word;
      tick();
      bus.inst_IF_flag = 1'b0;
      bus.inst_IF      = $urandom;
      check("fill_hit", {31'b0, bus.hit_flag}, 32'd1);
      check("fill_inst", bus.hit_inst, word);
      check("fill_req_low", {31'b0, bus.inst_IF_req}, 32'd0);
      model_fill(pc, word);
    end
    tick();
    check("no_double_hit", {31'b0, bus.hit_flag}, 32'd0);
    check("no_double_req", {31'b0, bus.inst_IF_req}, 32'd0);
    bus.fetch_req = 1'b0;
  endtask

  initial begin
    logic [31:0] pc;
    rst = 1'b1; rdy = 1'b1; jump_wrong = 1'b0;
    bus.fetch_req = 1'b0; bus.fetch_pc = '0;
    bus.inst_IF_flag = 1'b0; bus.inst_IF = '0;
    model_clear();
    tick(); tick();
    check("rst_hit_flag", {31'b0, bus.hit_flag}, 32'd0);
    check("rst_hit_inst", bus.hit_inst, 32'd0);
    check("rst_req", {31'b0, bus.inst_IF_req}, 32'd0);
    check("rst_addr", bus.inst_IF_addr, 32'd0);
    rst = 1'b0;
    tick();

    // Cold miss, then hit
    fetch(32'h0000_0104, 32'h0010_0093);
    fetch(32'h0000_0104, 32'hDEAD_BEEF);

    // Conflicting tags on index 1
    fetch(32'h0000_0004, 32'h1111_1111);
    fetch(32'h0000_0104, 32'h2222_2222);
    fetch(32'h0000_0004, 32'h3333_3333);
    fetch(32'h0000_0104, 32'h0010_0093);

    // Flush two cycles after the miss request rises
    bus.fetch_req = 1'b1; bus.fetch_pc = 32'h0000_0208;
    tick();
    check("flush_req_up", {31'b0, bus.inst_IF_req}, 32'd1);
    tick();
    jump_wrong = 1'b1;
    tick();
    jump_wrong = 1'b0; bus.fetch_req = 1'b0;
    check("flush_req_drop", {31'b0, bus.inst_IF_req}, 32'd0);
    check("flush_nohit", {31'b0, bus.hit_flag}, 32'd0);
    tick();
    check("flush_nohit2", {31'b0, bus.hit_flag}, 32'd0);
    fetch(32'h0000_0104, 32'hBAD0_0001);

    // Flush coincident with completion: line written, no hit_flag
    bus.fetch_req = 1'b1; bus.fetch_pc = 32'h0000_030C;
    tick();
    check("cflush_req_up", {31'b0, bus.inst_IF_req}, 32'd1);
    tick();
    jump_wrong = 1'b1; bus.inst_IF_flag = 1'b1; bus.inst_IF = 32'hCAFE_F00D;
    tick();
    jump_wrong = 1'b0; bus.inst_IF_flag = 1'b0; bus.fetch_req = 1'b0;
    check("cflush_nohit", {31'b0, bus.hit_flag}, 32'd0);
    check("cflush_req_low", {31'b0, bus.inst_IF_req}, 32'd0);
    model_fill(32'h0000_030C, 32'hCAFE_F00D);
    tick();
    fetch(32'h0000_030C, 32'hBAD0_0002);

    // rdy low for three cycles during a miss
    bus.fetch_req = 1'b1; bus.fetch_pc = 32'h0000_0410;
    tick();
    check("rdy_req_up", {31'b0, bus.inst_IF_req}, 32'd1);
    rdy = 1'b0;
    repeat (3) begin
      tick();
      check("rdy_hold_req", {31'b0, bus.inst_IF_req}, 32'd1);
      check("rdy_hold_addr", bus.inst_IF_addr, 32'h0000_0410);
      check("rdy_nohit", {31'b0, bus.hit_flag}, 32'd0);
    end
    rdy = 1'b1;
    tick();
    check("rdy_resume_req", {31'b0, bus.inst_IF_req}, 32'd1);
    bus.inst_IF_flag = 1'b1; bus.inst_IF = 32'h0BAD_CAFE;
    tick();
    bus.inst_IF_flag = 1'b0;
    check("rdy_fill_hit", {31'b0, bus.hit_flag}, 32'd1);
    check("rdy_fill_inst", bus.hit_inst, 32'h0BAD_CAFE);
    model_fill(32'h0000_0410, 32'h0BAD_CAFE);
    tick();
    check("rdy_no_double", {31'b0, bus.hit_flag}, 32'd0);
    bus.fetch_req = 1'b0;
    fetch(32'h0000_0410, 32'hBAD0_0003);

    // Asynchronous reset mid-miss
    bus.fetch_req = 1'b1; bus.fetch_pc = 32'h0000_051C;
    tick();
    check("arst_req_up", {31'b0, bus.inst_IF_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_req_drop", {31'b0, bus.inst_IF_req}, 32'd0);
    check("arst_addr", bus.inst_IF_addr, 32'd0);
    model_clear();
    bus.fetch_req = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    fetch(32'h0000_0104, 32'h0010_0093);

    // Random traffic over a small pool of tags and indices
    for (int n = 0; n < 60; n++) begin
      pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      fetch(pc, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
